// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, ALU commands, condition codes and mux selects for the multicycle controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXECR    = 4'd2,
    EXECI    = 4'd3,
    ALUWB    = 4'd4,
    MEMADR   = 4'd5,
    MEMREAD  = 4'd6,
    MEMWB    = 4'd7,
    MEMWRITE = 4'd8,
    BRANCH   = 4'd9,
    BXEX     = 4'd10
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [23:0] BX_PATTERN = 24'h12FFF1;

  function automatic logic is_dp_cmd(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
           (cmd == CMD_ORR) || (cmd == CMD_CMP) || (cmd == CMD_MOV);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/flag inputs and datapath control strobes
interface multicycle_controller_if #(parameter int STATE_W = 4);

  logic [31:0]        Instr;
  logic               zero_flag;
  logic               PCWrite;
  logic               MemWrite;
  logic               IRWrite;
  logic               AdrSrc;
  logic [1:0]         RegSrc;
  logic               RegWrite;
  logic [1:0]         ImmSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [3:0]         ALUControl;
  logic [1:0]         ResultSrc;
  logic [1:0]         bl_mux;
  logic [1:0]         shft_ctrl;
  logic [4:0]         shamt_ctrl;
  logic [1:0]         pc15_slct;
  logic               reg_ctrl;
  logic               bx_mux;
  logic               z_flag;
  logic               illegal;
  logic [STATE_W-1:0] state_out;

  modport master (
    input  Instr, zero_flag,
    output PCWrite, MemWrite, IRWrite, AdrSrc, RegSrc, RegWrite, ImmSrc,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, bl_mux, shft_ctrl,
           shamt_ctrl, pc15_slct, reg_ctrl, bx_mux, z_flag, illegal, state_out
  );

  modport slave (
    output Instr, zero_flag,
    input  PCWrite, MemWrite, IRWrite, AdrSrc, RegSrc, RegWrite, ImmSrc,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, bl_mux, shft_ctrl,
           shamt_ctrl, pc15_slct, reg_ctrl, bx_mux, z_flag, illegal, state_out
  );

endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - EQ/NE/AL condition evaluation against the held Z flag
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       z_flag,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_flag;
      COND_NE: pass = ~z_flag;
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle ARM-subset datapath
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                     clock,
  input  logic                     rst,
  multicycle_controller_if.master  bus
);

  state_t      state;
  logic        z_q;
  logic        cond_pass;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic        i_bit;
  logic [3:0]  cmd;
  logic        s_bit;
  logic        link;
  logic [3:0]  rd;
  logic        is_bx;
  logic        is_illegal;
  logic        unused_instr;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign i_bit = bus.Instr[25];
  assign cmd   = bus.Instr[24:21];
  assign s_bit = bus.Instr[20];
  assign link  = bus.Instr[24];
  assign rd    = bus.Instr[15:12];
  assign unused_instr = ^{bus.Instr[19:16], bus.Instr[3:0]};

  // BX shares op=00 with DP but uses a cmd value outside the DP set, so exempt it first
  assign is_bx      = (bus.Instr[27:4] == BX_PATTERN);
  assign is_illegal = ~is_bx &&
                      ((op == 2'b11) ||
                       ((op == 2'b00) && (~is_dp_cmd(cmd) || ((cmd == CMD_CMP) && ~s_bit))));

  cond_check u_cond_check (
    .cond   (cond),
    .z_flag (z_q),
    .pass   (cond_pass)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      z_q   <= 1'b0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          if (!cond_pass || is_illegal) state <= FETCH;
          else if (is_bx)               state <= BXEX;
          else if (op == 2'b10)         state <= BRANCH;
          else if (op == 2'b01)         state <= MEMADR;
          else if (i_bit)               state <= EXECI;
          else                          state <= EXECR;
        end
        EXECR, EXECI: begin
          if (s_bit) z_q <= bus.zero_flag;
          state <= (cmd == CMD_CMP) ? FETCH : ALUWB;
        end
        MEMADR:  state <= s_bit ? MEMREAD : MEMWRITE;
        MEMREAD: state <= MEMWB;
        default: state <= FETCH;
      endcase
    end
  end

  logic       pc_write, mem_write, ir_write, adr_src, reg_write, alu_src_a;
  logic       reg_ctrl, bx_mux, illegal;
  logic [1:0] reg_src, imm_src, alu_src_b, result_src, bl_mux, shft_ctrl, pc15_slct;
  logic [3:0] alu_control;
  logic [4:0] shamt_ctrl;

  always_comb begin
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    reg_ctrl    = 1'b0;
    bx_mux      = 1'b0;
    illegal     = 1'b0;
    reg_src     = 2'b00;
    imm_src     = IMM_8;
    alu_src_b   = SRCB_WD;
    result_src  = RES_ALUOUT;
    bl_mux      = 2'b00;
    shft_ctrl   = 2'b00;
    pc15_slct   = 2'b00;
    alu_control = CMD_AND;
    shamt_ctrl  = 5'd0;
    // The async reset only parks the state in FETCH; strobes stay quiet until release
    if (rst) begin
      case (state)
        FETCH: begin
          ir_write    = 1'b1;
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_FOUR;
          alu_control = CMD_ADD;
          result_src  = RES_ALURESULT;
          pc_write    = 1'b1;
          pc15_slct   = 2'b10;
          reg_ctrl    = 1'b1;
        end
        DECODE: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_FOUR;
          alu_control = CMD_ADD;
          result_src  = RES_ALURESULT;
          bx_mux      = is_bx;
          illegal     = is_illegal;
          if (op == 2'b10) begin
            reg_src = 2'b01;
            imm_src = IMM_24;
          end else if (op == 2'b01) begin
            reg_src = s_bit ? 2'b00 : 2'b10;
            imm_src = IMM_12;
          end
        end
        EXECR: begin
          alu_control = cmd;
          shft_ctrl   = bus.Instr[6:5];
          shamt_ctrl  = bus.Instr[11:7];
        end
        EXECI: begin
          alu_src_b   = SRCB_IMM;
          alu_control = cmd;
        end
        ALUWB: reg_write = (rd != 4'd15);
        MEMADR: begin
          alu_src_b   = SRCB_IMM;
          imm_src     = IMM_12;
          alu_control = CMD_ADD;
        end
        MEMREAD: adr_src = 1'b1;
        MEMWB: begin
          result_src = RES_DATA;
          reg_write  = (rd != 4'd15);
        end
        MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
          reg_src   = 2'b10;
        end
        BRANCH: begin
          // BL: PC already holds the return address, so R14 and PC load on one edge
          reg_src     = 2'b01;
          alu_src_b   = SRCB_IMM;
          imm_src     = IMM_24;
          alu_control = CMD_ADD;
          result_src  = RES_ALURESULT;
          pc_write    = 1'b1;
          reg_write   = link;
          bl_mux      = link ? 2'b11 : 2'b00;
        end
        BXEX: begin
          bx_mux      = 1'b1;
          alu_control = CMD_MOV;
          result_src  = RES_ALURESULT;
          pc_write    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.RegSrc     = reg_src;
  assign bus.RegWrite   = reg_write;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ResultSrc  = result_src;
  assign bus.bl_mux     = bl_mux;
  assign bus.shft_ctrl  = shft_ctrl;
  assign bus.shamt_ctrl = shamt_ctrl;
  assign bus.pc15_slct  = pc15_slct;
  assign bus.reg_ctrl   = reg_ctrl;
  assign bus.bx_mux     = bx_mux;
  assign bus.illegal    = illegal;
  assign bus.z_flag     = z_q;
  assign bus.state_out  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed instruction sequences with hand-computed strobes
module tb_multicycle_controller;

  logic clock;
  logic rst;
  int   n_checks;
  int   n_pass;

  multicycle_controller_if #(.STATE_W(4)) bus_if ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic check_fetch(input string tag);
    check({tag, "_state"}, 32'(bus_if.state_out), 32'd0);
    check({tag, "_irw"},   32'(bus_if.IRWrite),   32'd1);
    check({tag, "_pcw"},   32'(bus_if.PCWrite),   32'd1);
    check({tag, "_regw"},  32'(bus_if.RegWrite),  32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    bus_if.Instr = 32'hE0821003;
    bus_if.zero_flag = 1'b0;
    repeat (2) cyc();
    check("rst_state", 32'(bus_if.state_out), 32'd0);
    check("rst_irw",   32'(bus_if.IRWrite),   32'd0);
    check("rst_pcw",   32'(bus_if.PCWrite),   32'd0);
    check("rst_z",     32'(bus_if.z_flag),    32'd0);

    // ADD R1,R2,R3
    rst = 1'b1;
    #1;
    check_fetch("add_f");
    check("add_f_srcb",  32'(bus_if.ALUSrcB),    32'd2);
    check("add_f_res",   32'(bus_if.ResultSrc),  32'd2);
    check("add_f_pc15",  32'(bus_if.pc15_slct),  32'd2);
    check("add_f_rctl",  32'(bus_if.reg_ctrl),   32'd1);
    check("add_f_alu",   32'(bus_if.ALUControl), 32'd4);
    cyc();
    check("add_d_state", 32'(bus_if.state_out),  32'd1);
    check("add_d_regw",  32'(bus_if.RegWrite),   32'd0);
    check("add_d_pc15",  32'(bus_if.pc15_slct),  32'd0);
    check("add_d_srca",  32'(bus_if.ALUSrcA),    32'd1);
    check("add_d_ill",   32'(bus_if.illegal),    32'd0);
    cyc();
    check("add_e_state", 32'(bus_if.state_out),  32'd2);
    check("add_e_alu",   32'(bus_if.ALUControl), 32'd4);
    check("add_e_srca",  32'(bus_if.ALUSrcA),    32'd0);
    check("add_e_srcb",  32'(bus_if.ALUSrcB),    32'd0);
    check("add_e_regw",  32'(bus_if.RegWrite),   32'd0);
    cyc();
    check("add_w_state", 32'(bus_if.state_out),  32'd4);
    check("add_w_regw",  32'(bus_if.RegWrite),   32'd1);
    check("add_w_res",   32'(bus_if.ResultSrc),  32'd0);
    cyc();
    check_fetch("ldr_f");

    // LDR R0,[R1,#4]
    bus_if.Instr = 32'hE5910004;
    cyc();
    check("ldr_d_state", 32'(bus_if.state_out),  32'd1);
    check("ldr_d_imm",   32'(bus_if.ImmSrc),     32'd1);
    check("ldr_d_rsrc",  32'(bus_if.RegSrc),     32'd0);
    cyc();
    check("ldr_a_state", 32'(bus_if.state_out),  32'd5);
    check("ldr_a_imm",   32'(bus_if.ImmSrc),     32'd1);
    check("ldr_a_srcb",  32'(bus_if.ALUSrcB),    32'd1);
    cyc();
    check("ldr_r_state", 32'(bus_if.state_out),  32'd6);
    check("ldr_r_adr",   32'(bus_if.AdrSrc),     32'd1);
    check("ldr_r_mw",    32'(bus_if.MemWrite),   32'd0);
    cyc();
    check("ldr_w_state", 32'(bus_if.state_out),  32'd7);
    check("ldr_w_res",   32'(bus_if.ResultSrc),  32'd1);
    check("ldr_w_regw",  32'(bus_if.RegWrite),   32'd1);
    cyc();
    check_fetch("str_f");

    // STR R0,[R1,#4]
    bus_if.Instr = 32'hE5810004;
    cyc();
    check("str_d_rsrc",  32'(bus_if.RegSrc),     32'd2);
    cyc();
    check("str_a_state", 32'(bus_if.state_out),  32'd5);
    check("str_a_mw",    32'(bus_if.MemWrite),   32'd0);
    cyc();
    check("str_m_state", 32'(bus_if.state_out),  32'd8);
    check("str_m_mw",    32'(bus_if.MemWrite),   32'd1);
    check("str_m_rsrc",  32'(bus_if.RegSrc),     32'd2);
    check("str_m_regw",  32'(bus_if.RegWrite),   32'd0);
    cyc();
    check("str_end_mw",  32'(bus_if.MemWrite),   32'd0);
    check_fetch("cmp_f");

    // CMP R0,R0 with ALU zero
    bus_if.Instr = 32'hE1500000;
    bus_if.zero_flag = 1'b1;
    cyc();
    check("cmp_d_state", 32'(bus_if.state_out),  32'd1);
    cyc();
    check("cmp_e_state", 32'(bus_if.state_out),  32'd2);
    check("cmp_e_alu",   32'(bus_if.ALUControl), 32'd10);
    check("cmp_e_z",     32'(bus_if.z_flag),     32'd0);
    cyc();
    check_fetch("beq_f");
    check("cmp_z_set",   32'(bus_if.z_flag),     32'd1);

    // BEQ taken
    bus_if.Instr = 32'h0A000001;
    bus_if.zero_flag = 1'b0;
    cyc();
    check("beq_d_rsrc",  32'(bus_if.RegSrc),     32'd1);
    check("beq_d_imm",   32'(bus_if.ImmSrc),     32'd2);
    cyc();
    check("beq_b_state", 32'(bus_if.state_out),  32'd9);
    check("beq_b_pcw",   32'(bus_if.PCWrite),    32'd1);
    check("beq_b_regw",  32'(bus_if.RegWrite),   32'd0);
    check("beq_b_bl",    32'(bus_if.bl_mux),     32'd0);
    cyc();
    check_fetch("bne_f");

    // BNE not taken
    bus_if.Instr = 32'h1A000001;
    cyc();
    check("bne_d_state", 32'(bus_if.state_out),  32'd1);
    check("bne_d_pcw",   32'(bus_if.PCWrite),    32'd0);
    cyc();
    check("bne_back",    32'(bus_if.state_out),  32'd0);

    // BL
    bus_if.Instr = 32'hEB000002;
    cyc();
    cyc();
    check("bl_b_state",  32'(bus_if.state_out),  32'd9);
    check("bl_b_regw",   32'(bus_if.RegWrite),   32'd1);
    check("bl_b_bl",     32'(bus_if.bl_mux),     32'd3);
    check("bl_b_pcw",    32'(bus_if.PCWrite),    32'd1);
    cyc();
    check_fetch("bx_f");

    // BX LR
    bus_if.Instr = 32'hE12FFF1E;
    cyc();
    check("bx_d_state",  32'(bus_if.state_out),  32'd1);
    check("bx_d_bx",     32'(bus_if.bx_mux),     32'd1);
    check("bx_d_ill",    32'(bus_if.illegal),    32'd0);
    cyc();
    check("bx_x_state",  32'(bus_if.state_out),  32'd10);
    check("bx_x_alu",    32'(bus_if.ALUControl), 32'd13);
    check("bx_x_pcw",    32'(bus_if.PCWrite),    32'd1);
    check("bx_x_bx",     32'(bus_if.bx_mux),     32'd1);
    cyc();
    check_fetch("addi_f");

    // ADD PC,PC,#5: immediate path with Rd=15 write suppressed
    bus_if.Instr = 32'hE28FF005;
    cyc();
    cyc();
    check("addi_e_state", 32'(bus_if.state_out), 32'd3);
    check("addi_e_srcb",  32'(bus_if.ALUSrcB),   32'd1);
    cyc();
    check("addi_w_state", 32'(bus_if.state_out), 32'd4);
    check("addi_w_regw",  32'(bus_if.RegWrite),  32'd0);
    cyc();
    check_fetch("ill_f");

    // op=11 is illegal
    bus_if.Instr = 32'hEC000000;
    cyc();
    check("ill_d_state", 32'(bus_if.state_out),  32'd1);
    check("ill_d_ill",   32'(bus_if.illegal),    32'd1);
    check("ill_d_regw",  32'(bus_if.RegWrite),   32'd0);
    check("ill_d_mw",    32'(bus_if.MemWrite),   32'd0);
    check("ill_d_pcw",   32'(bus_if.PCWrite),    32'd0);
    cyc();
    check("ill_back",    32'(bus_if.state_out),  32'd0);
    check("ill_clear",   32'(bus_if.illegal),    32'd0);
    check("z_held",      32'(bus_if.z_flag),     32'd1);

    // Reset in the middle of a store
    bus_if.Instr = 32'hE5810004;
    cyc();
    cyc();
    cyc();
    check("rmid_state",  32'(bus_if.state_out),  32'd8);
    check("rmid_mw",     32'(bus_if.MemWrite),   32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rmid_mw_drop", 32'(bus_if.MemWrite),  32'd0);
    check("rmid_fetch",   32'(bus_if.state_out), 32'd0);
    check("rmid_z",       32'(bus_if.z_flag),    32'd0);
    check("rmid_irw",     32'(bus_if.IRWrite),   32'd0);
    cyc();
    rst = 1'b1;
    #1;
    check_fetch("rel_f");
    cyc();
    check("rel_d_state", 32'(bus_if.state_out),  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset datapath. It sits directly upstream of that datapath.
- Consumes the latched instruction and zero_flag.
- Produces every datapath control strobe, one Moore state per instruction phase.
- Holds the Z condition flag. Evaluates the EQ/NE/AL conditions. Sequences the DP, LDR/STR, B, BL and BX instructions.

Parameters:
STATE_W, 4, width of the state register and of state_out

Ports:
clock  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
Instr  input  32  instruction register contents from the datapath
zero_flag  input  1  ALU zero output, combinational, current cycle
PCWrite  output  1  PC register load
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
AdrSrc  output  1  0: address is PC; 1: address is Result
RegSrc  output  2  [0]: RA1=R15; [1]: RA2=Instr[15:12]
RegWrite  output  1  register file write
ImmSrc  output  2  extender mode: 00 imm8, 01 imm12, 10 imm24<<2
ALUSrcA  output  1  0: A; 1: PC
ALUSrcB  output  2  00 WriteData, 01 ExtImm, 10 constant 4
ALUControl  output  4  ALU operation, ARM cmd encoding
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
bl_mux  output  2  [0]: destination R14; [1]: write data = PC
shft_ctrl  output  2  shifter type
shamt_ctrl  output  5  shift amount
pc15_slct  output  2  R15 read source: 00 latched, 01 Result, 10 Result+4
reg_ctrl  output  1  latch for the R15 shadow register
bx_mux  output  1  forces RA2=R14
z_flag  output  1  registered Z flag
illegal  output  1  high in DECODE for an unsupported encoding
state_out  output  STATE_W  current state, for debug

Behaviour:
- Reset:
  - rst low forces state=FETCH and z_flag=0, asynchronously.
  - While rst is low, every control output is forced to 0.
  - The first FETCH occurs on the first rising edge after rst deasserts.
- Outputs are Moore, combinational from the state plus Instr fields. The only registers are the state and z_flag. Any output not listed for a state is 0.
- Decode fields:
  - cond=Instr[31:28], op=Instr[27:26], I=Instr[25], cmd=Instr[24:21], S/L=Instr[20].
  - For branches, link bit = Instr[24].
  - BX is recognised as Instr[27:4]=0x12FFF1.
- Condition pass:
  - EQ (0000): pass when z_flag=1.
  - NE (0001): pass when z_flag=0.
  - AL (1110): always pass.
  - Any other cond: never passes.
- Supported DP commands: AND 0000, SUB 0010, ADD 0100, ORR 1100, CMP 1010, MOV 1101. ALUControl = cmd in the EXEC states.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1, pc15_slct=10, reg_ctrl=1. Next state is DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, pc15_slct=00.
  - RegSrc by class: B=01, STR=10, others=00.
  - bx_mux=1 for BX.
  - ImmSrc by class: DP imm=00, mem=01, branch=10.
  - Next state:
    - cond fails or illegal -> FETCH.
    - BX -> BXEX.
    - op=10 -> BRANCH.
    - op=01 -> MEMADR.
    - op=00 with I=1 -> EXECI.
    - op=00 with I=0 -> EXECR.
- EXECR:
  - ALUSrcA=0, ALUSrcB=00, shft_ctrl=Instr[6:5], shamt_ctrl=Instr[11:7].
  - Next state: ALUWB, or FETCH when cmd=CMP.
- EXECI:
  - ALUSrcA=0, ALUSrcB=01, ImmSrc=00, shamt_ctrl=0.
  - Next state: same rule as EXECR.
- Z flag update:
  - z_flag loads zero_flag at the end of EXECR/EXECI when S=1 or cmd=CMP.
  - The CMP encoding requires S=1; CMP with S=0 is illegal.
- ALUWB:
  - ResultSrc=00, RegWrite=1. RegWrite is forced to 0 when Instr[15:12]=15 (PC writes are unsupported and suppressed).
  - Next state is FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl=ADD. Next state: MEMREAD if L=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, with the same Rd=15 suppression as ALUWB. Next state is FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, RegSrc=10. Next state is FETCH.
- BRANCH:
  - RegSrc=01, ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - If link=1, also RegWrite=1 and bl_mux=11. This writes PC (already PC+4) to R14 on the same edge that PC loads the target.
  - Next state is FETCH.
- BXEX:
  - bx_mux=1, ALUSrcB=00, ALUControl=MOV, ResultSrc=10, PCWrite=1.
  - The datapath always sources R14, so Instr[3:0]≠14 is still executed as BX R14.
  - Next state is FETCH.
- Illegal encodings: op=11; cmd outside the supported set; CMP with S=0. illegal=1 in DECODE; the instruction is then a NOP.
- Latency in cycles: DP=4, CMP=3, LDR=5, STR=4, B/BL=3, BX=3, failed-cond or illegal=2.
- Reset asserted mid-instruction: the instruction is abandoned, no further strobes are issued, and z_flag clears.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum: FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BRANCH, BXEX;
  - the ALU cmd constants;
  - the cond constants;
  - the ImmSrc/ResultSrc/ALUSrcB constants.
- One sub-module, cond_check: combinational; inputs cond and z_flag; output pass.

Test Plan:
- Release rst, Instr=0xE0821003 (ADD R1,R2,R3) -> states FETCH, DECODE, EXECR, ALUWB; then FETCH with IRWrite=1 and PCWrite=1; RegWrite=1 only in ALUWB; ALUControl=0100 in EXECR.
- Instr=0xE5910004 (LDR R0,[R1,#4]) -> 5 cycles; ImmSrc=01 in MEMADR; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB. Then 0xE5810004 (STR) -> MemWrite=1 for exactly one cycle, RegSrc=10.
- 0xE1500000 (CMP R0,R0) with zero_flag=1 -> z_flag=1 after EXECR, no RegWrite; then 0x0A000001 (BEQ) -> BRANCH with PCWrite=1; then 0x1A000001 (BNE) -> FETCH, DECODE, FETCH with no PCWrite outside FETCH.
- 0xEB000002 (BL) -> BRANCH asserts RegWrite=1, bl_mux=11, PCWrite=1 together. Then 0xE12FFF1E (BX LR) -> DECODE bx_mux=1, BXEX ALUControl=1101 and PCWrite=1.
- 0xEC000000 (op=11) -> illegal=1 in DECODE, return to FETCH, no write strobes. Pull rst low during MEMWRITE -> MemWrite drops immediately; state_out=FETCH; z_flag=0.
